// File: rtl/fifo_pkg.sv
// Shared FIFO types: count-width helper and the sticky error-flag bundle.
package fifo_pkg;

  // Occupancy counter must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around address counter: advances by one when en is high, DEPTH-1 -> 0.
module fifo_ptr #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with level flags and sticky errors.
// Define SYNC_FIFO_OVERWRITE_EN to make a write-only into a full FIFO replace the oldest entry.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      ren,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     waddr, raddr;
  logic              at_full, at_empty;
  logic              rd_ok, wr_adv, rd_adv;
  logic              ovf_set, unf_set;
  err_flags_t        err_q;

  assign at_full  = (count == CW'(DEPTH));
  assign at_empty = (count == '0);
  assign rd_ok    = ren && !at_empty;
  assign ovf_set  = wen && !ren && at_full;
  assign unf_set  = ren && at_empty;

`ifdef SYNC_FIFO_OVERWRITE_EN
  // Full write-only drops the head by advancing both pointers together.
  assign wr_adv = wen;
  assign rd_adv = rd_ok || ovf_set;
`else
  assign wr_adv = wen && (!at_full || ren);
  assign rd_adv = rd_ok;
`endif

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PW)) u_wptr (
    .clk(clk), .rst_n(rst_n), .en(wr_adv), .ptr(waddr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PW)) u_rptr (
    .clk(clk), .rst_n(rst_n), .en(rd_adv), .ptr(raddr)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_adv)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (wr_adv && !rd_adv)
      count <= count + CW'(1);
    else if (rd_adv && !wr_adv)
      count <= count - CW'(1);
  end

  // A set event outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= ovf_set || (err_q.overflow  && !clr_err);
      err_q.underflow <= unf_set || (err_q.underflow && !clr_err);
    end
  end

  assign full         = at_full;
  assign empty        = at_empty && rst_n;
  assign almost_full  = (int'(count) >= AFULL_TH) && rst_n;
  assign almost_empty = (int'(count) <= AEMPTY_TH) && rst_n;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed checks of sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wen, ren, clr;
  logic [7:0] wd, rd;
  logic [4:0] cnt;
  logic       full, empty, af, ae, ovf, unf;

  logic       wen5, ren5, clr5;
  logic [7:0] wd5, rd5;
  logic [3:0] cnt5;
  logic       full5, empty5, af5, ae5, ovf5, unf5;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  bit         m_ovf, m_unf;

  sync_fifo_flags #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wd), .ren(ren), .clr_err(clr),
    .rdata(rd), .count(cnt), .full(full), .empty(empty), .almost_full(af),
    .almost_empty(ae), .overflow(ovf), .underflow(unf)
  );

  sync_fifo_flags #(.DATA_W(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .wen(wen5), .wdata(wd5), .ren(ren5), .clr_err(clr5),
    .rdata(rd5), .count(cnt5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .overflow(ovf5), .underflow(unf5)
  );

  // One clock of stimulus on the DEPTH=16 instance, then the model applies the same request.
  task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
    int n;
    bit pop, push;
    wen = w; ren = r; clr = c; wd = d;
    @(posedge clk); #1;
    n     = q.size();
    pop   = r && n > 0;
    push  = w && (n < 16 || r);
    m_ovf = (w && !r && n == 16) || (m_ovf && !c);
    m_unf = (r && n == 0) || (m_unf && !c);
`ifdef SYNC_FIFO_OVERWRITE_EN
    if (w && !r && n == 16) begin pop = 1'b1; push = 1'b1; end
`endif
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({full, empty, af, ae, ovf, unf} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {full, empty, af, ae, ovf, unf});
    end
    n_chk++;
    if (cnt !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (empty !== 1'b1 || ae !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_release empty=%b ae=%b full=%b want 1 1 0", empty, ae, full);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      n_chk++;
      if (cnt !== 5'(i)) begin n_fail++; $display("FAIL fill_count i=%0d got %0d want %0d", i, cnt, i); end
      n_chk++;
      if (af !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull i=%0d got %b want %b", i, af, i >= 14); end
    end
    n_chk++;
    if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%b empty=%b want 1 0", full, empty); end
    n_chk++;
    if (rd !== 8'h01) begin n_fail++; $display("FAIL fill_head got %h want 01", rd); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      n_chk++;
      if (rd !== 8'(i)) begin n_fail++; $display("FAIL drain_data i=%0d got %h want %h", i, rd, 8'(i)); end
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    n_chk++;
    if (empty !== 1'b1 || cnt !== 5'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b cnt=%0d want 1 0", empty, cnt); end
    n_chk++;
    if (unf !== 1'b0) begin n_fail++; $display("FAIL drain_unf got %b want 0", unf); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    n_chk++;
    if (cnt !== 5'd0 || unf !== 1'b1) begin n_fail++; $display("FAIL unf_set got cnt=%0d unf=%b want 0 1", cnt, unf); end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_hold got %b want 1", unf); end
    // Write and read together on an empty FIFO: write only, underflow again.
    step(1'b1, 1'b1, 1'b1, 8'h5C);
    n_chk++;
    if (cnt !== 5'd1 || unf !== 1'b1 || rd !== 8'h5C) begin
      n_fail++; $display("FAIL unf_wr_rd got cnt=%0d unf=%b rd=%h want 1 1 5c", cnt, unf, rd);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    n_chk++;
    if (unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", unf); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_overflow();
    bit saw_aa = 1'b0;
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    n_chk++;
    if (ovf !== 1'b1 || cnt !== 5'd16) begin n_fail++; $display("FAIL ovf_set got ovf=%b cnt=%0d want 1 16", ovf, cnt); end
`ifdef SYNC_FIFO_OVERWRITE_EN
    n_chk++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL ovf_head got %h want 02", rd); end
`else
    n_chk++;
    if (rd !== 8'h01) begin n_fail++; $display("FAIL ovf_head got %h want 01", rd); end
`endif
    // Full with simultaneous read and write: both accepted, no new overflow cause.
    step(1'b1, 1'b1, 1'b1, 8'h77);
    n_chk++;
    if (cnt !== 5'd16 || ovf !== 1'b0) begin n_fail++; $display("FAIL full_wr_rd got cnt=%0d ovf=%b want 16 0", cnt, ovf); end
    while (q.size() > 0) begin
      n_chk++;
      if (rd !== q[0]) begin n_fail++; $display("FAIL ovf_drain got %h want %h", rd, q[0]); end
      if (rd === 8'hAA) saw_aa = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
`ifndef SYNC_FIFO_OVERWRITE_EN
    n_chk++;
    if (saw_aa) begin n_fail++; $display("FAIL ovf_dropped got 0xAA read back want never"); end
`endif
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 25));
      r = ($urandom_range(0, 99) < ((i % 100) < 50 ? 25 : 75));
      c = ($urandom_range(0, 15) == 0);
      step(w, r, c, 8'($urandom));
      n_chk++;
      if (cnt !== q.size() || full !== (q.size() == 16) || empty !== (q.size() == 0) ||
          af !== (q.size() >= 14) || ae !== (q.size() <= 2)) begin
        n_fail++; $display("FAIL rand_level i=%0d got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d",
                           i, cnt, full, empty, af, ae, q.size());
      end
      n_chk++;
      if (ovf !== m_ovf || unf !== m_unf) begin
        n_fail++; $display("FAIL rand_err i=%0d got ovf=%b unf=%b want %b %b", i, ovf, unf, m_ovf, m_unf);
      end
      if (q.size() > 0) begin
        n_chk++;
        if (rd !== q[0]) begin n_fail++; $display("FAIL rand_data i=%0d got %h want %h", i, rd, q[0]); end
      end
    end
  endtask

  task automatic test_wrap5();
    logic [7:0] q5[$];
    logic [7:0] v;
    for (int i = 0; i < 24; i++) begin
      wen5 = (i % 2 == 0); ren5 = (i % 2 == 1); clr5 = 1'b0;
      v = 8'h30 + 8'(i / 2); wd5 = v;
      if (ren5) begin
        n_chk++;
        if (rd5 !== q5[0]) begin n_fail++; $display("FAIL wrap5_data i=%0d got %h want %h", i, rd5, q5[0]); end
      end
      @(posedge clk); #1;
      if (ren5) void'(q5.pop_front());
      else q5.push_back(v);
      n_chk++;
      if (cnt5 !== q5.size() || cnt5 > 4'd5) begin
        n_fail++; $display("FAIL wrap5_count i=%0d got %0d want %0d", i, cnt5, q5.size());
      end
    end
    wen5 = 1'b0; ren5 = 1'b0;
    n_chk++;
    if (empty5 !== 1'b1 || unf5 !== 1'b0 || ovf5 !== 1'b0) begin
      n_fail++; $display("FAIL wrap5_end got empty=%b unf=%b ovf=%b want 1 0 0", empty5, unf5, ovf5);
    end
  endtask

  task automatic test_mid_reset();
    while (q.size() > 7) step(1'b0, 1'b1, 1'b0, 8'h00);
    while (q.size() < 7) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h99);
    n_chk++;
    if (cnt !== 5'd7) begin n_fail++; $display("FAIL mrst_pre got %0d want 7", cnt); end
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_chk++;
    if ({full, empty, af, ae, ovf, unf} !== 6'b0 || cnt !== 5'd0) begin
      n_fail++; $display("FAIL mrst_during got flags=%b cnt=%0d want 000000 0", {full, empty, af, ae, ovf, unf}, cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (empty !== 1'b1 || cnt !== 5'd0) begin n_fail++; $display("FAIL mrst_after got empty=%b cnt=%0d want 1 0", empty, cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; clr = 1'b0; wd = '0;
    wen5 = 1'b0; ren5 = 1'b0; clr5 = 1'b0; wd5 = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_overflow();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    test_random();
    test_wrap5();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (>=2; need not be a power of two).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port wen  input  1  write request.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port ren  input  1  read request (pops the current head).
REQ-010 SHALL have port clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 SHALL have port rdata  output  DATA_W  head-of-queue data, first-word fall-through.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL write wdata to mem[waddr] on a clock edge with an accepted write; rdata SHALL be mem[raddr] combinationally (zero read latency).
REQ-016 SHALL advance waddr/raddr by 1 per accepted write/read and wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write when !full, or when ren is also high.
REQ-018 SHALL accept a read when count>0; a read with count==0 SHALL be ignored (pointers and count unchanged) and SHALL set underflow.
REQ-019 SHALL update count +1 on write-only, -1 on read-only, and leave it unchanged on simultaneous accepted write and read; count SHALL never exceed DEPTH.
REQ-020 SHALL, on wen&&ren with count==0, accept the write only (count 0->1) and set underflow.
REQ-021 SHALL, on wen&&ren with count==DEPTH, accept both (count stays DEPTH, no overflow).
REQ-022 SHALL drive full=(count==DEPTH), empty=(count==0)&&rst_n, almost_full=(count>=AFULL_TH), almost_empty=(count<=AEMPTY_TH)&&rst_n.
REQ-023 SHALL hold overflow/underflow at 1 once set until clr_err is high on a clock edge; a set event coincident with clr_err SHALL win (flag stays 1).

Reset
REQ-024 SHALL, while rst_n is low, hold waddr, raddr and count at 0, and hold full, empty, almost_full, almost_empty, overflow and underflow at 0.
REQ-025 SHALL NOT reset storage contents; rdata is undefined until the first write after reset.
REQ-026 SHALL discard all queued data when rst_n is asserted mid-operation; the first cycle after release SHALL show empty=1 and count=0.

Configuration
REQ-027 SHALL use the macro SYNC_FIFO_OVERWRITE_EN.
- Defined: write-only when full overwrites the oldest entry, advancing waddr and raddr, with count staying DEPTH; overflow sets.
- Undefined: write-only when full is dropped, with pointers, count and memory unchanged; overflow sets.

Structure
REQ-028 SHALL take the width helper constant and the error-flag enum/struct type from shared package fifo_pkg.
REQ-029 SHALL instantiate the sub-module fifo_ptr (parametrised wrap counter with enable and async reset) twice, once each for waddr and raddr.

Verification
REQ-030 Reset, then 16 writes of 0x01..0x10 at DEPTH=16 -> full=1, count=16, almost_full asserted from count 14, rdata=0x01.
REQ-031 From the full state, 16 reads -> rdata sequence 0x01..0x10, empty=1 after the last read, underflow=0.
REQ-032 Read while empty -> count stays 0, underflow=1 and held; clr_err pulse -> underflow=0 on the next cycle.
REQ-033 Full, then write 0xAA with ren=0:
- With SYNC_FIFO_OVERWRITE_EN defined -> rdata=0x02, count=16, overflow=1.
- Without it -> rdata=0x01, 0xAA is never read back, overflow=1.
REQ-034 DEPTH=5 with 12 writes interleaved with 12 reads (1 write then alternating) -> pointers wrap 4->0, data order is preserved, count stays <=5.
REQ-035 rst_n low for one cycle with count=7 -> all flags 0 during reset, then empty=1 and count=0 after release.
